decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV64I instruction decode stage; sits directly downstream of the fetch stage.
//  Accepts one 32-bit instruction plus its PC over a valid/ready handshake.
//  Decodes it into register indices, a sign-extended immediate, an ALU op and
//  control flags, held in one pipeline register for the execute stage.
//  Single-entry buffer; no register-file access inside this block.
// PARAMETERS
//  XLEN   64  datapath / immediate width
//  PC_W   64  program-counter width
//  CNT_W  32  performance-counter width (used only with DECODE_PERF_EN)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  if_valid     in   1      fetch presents an instruction
//  if_ready     out  1      decode can accept this cycle
//  if_instr     in   32     raw instruction word
//  if_pc        in   PC_W   PC of if_instr
//  flush        in   1      kill the held and the incoming instruction (redirect)
//  id_valid     out  1      decoded bundle valid
//  id_ready     in   1      execute consumes the bundle
//  id_pc        out  PC_W   PC of the decoded instruction
//  id_rs1/rs2/rd out 5 each raw register fields [19:15]/[24:20]/[11:7]
//  id_funct3    out  3      instr[14:12]
//  id_imm       out  XLEN   sign-extended immediate (0 for R-type)
//  id_alu_op    out  4      alu_op_t
//  id_ctrl      out  ctrl_t {reg_write,mem_read,mem_write,branch,jal,jalr,
//                             alu_src_imm,is_word,use_rs1,use_rs2}
//  id_illegal   out  1      unsupported or illegal encoding
// BEHAVIOUR
//  - Reset (async): id_valid=0; all id_* outputs 0; if_ready=1 while reset deasserted.
//  - Two-state occupancy: EMPTY (id_valid=0) / FULL (id_valid=1).
//  - if_ready = !id_valid || id_ready (combinational; no bubble at full throughput).
//  - Accept when if_valid && if_ready && !flush: bundle is registered; id_valid=1
//    next cycle (latency 1).
//  - FULL && id_ready && no accept -> EMPTY. FULL && id_ready && accept -> stays FULL
//    with new bundle.
//  - FULL && !id_ready: all id_* outputs held stable; nothing is accepted.
//  - flush: id_valid=0 next cycle. Overrides a same-cycle accept; the incoming word is dropped.
//  - Immediates: I, S, B, U and J formats; sign-extended from instr[31] to XLEN.
//    The B/J LSB is 0. U-type is {instr[31:12],12'b0} sign-extended.
//  - Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM,
//    OP, OP-IMM-32, OP-32. is_word=1 for the *-32 opcodes.
//  - reg_write is forced to 0 when rd==0.
//  - Illegal: any other opcode, bad funct3/funct7 combination, or instr==0.
//    Result: id_illegal=1, id_ctrl=0, id_alu_op=ALU_ADD; the bundle still
//    handshakes normally.
// CONFIGURATION
//  DECODE_PERF_EN defined: adds output ports id_decoded_cnt and id_stall_cnt
//  (CNT_W each, reset 0, wrap at 2^CNT_W). id_decoded_cnt +1 per accept.
//  id_stall_cnt +1 per cycle with id_valid && !id_ready.
//  DECODE_PERF_EN undefined: the ports and counters are absent; behaviour is
//  otherwise identical.
// STRUCTURE
//  Package decode_pkg holds:
//   - opcode_e constants: 7'b0110111 LUI, ..., 7'b0111011 OP-32
//   - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B
//   - imm_fmt_e enum: I, S, B, U, J, NONE
//   - ctrl_t packed struct
//  Sub-module imm_gen: combinational; (instr, imm_fmt_e) -> XLEN immediate.
//  All remaining logic lives in decode_stage.
// TESTING
//  1. 0xFFF00093 (addi x1,x0,-1), pc 0x1000 -> next cycle:
//     id_valid=1, rd=1, rs1=0, imm=0xFFFF_FFFF_FFFF_FFFF, ALU_ADD,
//     reg_write=1, alu_src_imm=1, id_pc=0x1000.
//  2. 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFF_FFFF_FFFF_FFFC, branch=1,
//     use_rs1=use_rs2=1, reg_write=0.
//  3. id_ready=0 for 3 cycles while if_valid=1 -> if_ready=0 and id_* stable.
//     Raise id_ready -> the next instruction is accepted that same cycle.
//  4. flush together with if_valid=1 while FULL -> id_valid=0 next cycle.
//     The dropped instruction never appears on id_*.
//  5. 0x00000000, then 0x0000007F -> id_illegal=1 and id_ctrl=0 for both;
//     0x00000513 (addi x10,x0,0) -> legal.
//  6. Assert reset while FULL and stalled -> id_valid=0 immediately. After
//     release, if_ready=1; with DECODE_PERF_EN both counters read 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the RV64I decode stage: opcodes, ALU ops, immediate formats, control bundle.
package decode_pkg;

  typedef enum logic [6:0] {
    OPC_LUI       = 7'b0110111,
    OPC_AUIPC     = 7'b0010111,
    OPC_JAL       = 7'b1101111,
    OPC_JALR      = 7'b1100111,
    OPC_BRANCH    = 7'b1100011,
    OPC_LOAD      = 7'b0000011,
    OPC_STORE     = 7'b0100011,
    OPC_OP_IMM    = 7'b0010011,
    OPC_OP        = 7'b0110011,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_OP_32     = 7'b0111011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jal;
    logic jalr;
    logic alu_src_imm;
    logic is_word;
    logic use_rs1;
    logic use_rs2;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // alt selects SUB/SRA; callers only set it where the encoding allows it.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: assembles the I/S/B/U/J immediate and sign-extends it to XLEN.
module decode_stage_imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:7]     instr_i,
  input  logic [2:0]      fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_fmt_e'(fmt_i))
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = {{(XLEN-32){imm32[31]}}, imm32};

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage with a single-entry output register and valid/ready handshakes.
// Optional perf counters are enabled by defining DECODE_PERF_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [4:0]        id_rs1,
  output logic [4:0]        id_rs2,
  output logic [4:0]        id_rd,
  output logic [2:0]        id_funct3,
  output logic [XLEN-1:0]   id_imm,
  output logic [3:0]        id_alu_op,
  output logic [CTRL_W-1:0] id_ctrl,
  output logic              id_illegal
`ifdef DECODE_PERF_EN
  ,
  output logic [CNT_W-1:0]  id_decoded_cnt,
  output logic [CNT_W-1:0]  id_stall_cnt
`endif
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = if_instr[6:0];
  assign funct3 = if_instr[14:12];
  assign funct7 = if_instr[31:25];
  assign rd     = if_instr[11:7];

  ctrl_t           dec_ctrl;
  alu_op_t         dec_alu;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_ctrl    = '0;
    dec_alu     = ALU_ADD;
    dec_fmt     = IMM_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_fmt              = IMM_U;
        dec_alu              = ALU_PASS_B;
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
      end
      OPC_AUIPC: begin
        dec_fmt              = IMM_U;
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
      end
      OPC_JAL: begin
        dec_fmt            = IMM_J;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.jal       = 1'b1;
      end
      OPC_JALR: begin
        dec_fmt              = IMM_I;
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.jalr        = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.use_rs1     = 1'b1;
        dec_illegal          = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_fmt          = IMM_B;
        dec_ctrl.branch  = 1'b1;
        dec_ctrl.use_rs1 = 1'b1;
        dec_ctrl.use_rs2 = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_alu = ALU_SUB;
          3'b100, 3'b101: dec_alu = ALU_SLT;
          3'b110, 3'b111: dec_alu = ALU_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_fmt              = IMM_I;
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.mem_read    = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.use_rs1     = 1'b1;
        dec_illegal          = (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec_fmt              = IMM_S;
        dec_ctrl.mem_write   = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.use_rs1     = 1'b1;
        dec_ctrl.use_rs2     = 1'b1;
        dec_illegal          = funct3[2];
      end
      OPC_OP_IMM: begin
        dec_fmt              = IMM_I;
        dec_alu              = alu_from_funct3(funct3, (funct3 == 3'b101) && if_instr[30]);
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.use_rs1     = 1'b1;
        // RV64 shamt is 6 bits, so only instr[31:26] constrain the shift encodings
        if (funct3 == 3'b001) dec_illegal = (if_instr[31:26] != 6'b000000);
        if (funct3 == 3'b101) dec_illegal = ({if_instr[31], if_instr[29:26]} != 5'b00000);
      end
      OPC_OP: begin
        dec_alu            = alu_from_funct3(funct3, if_instr[30]);
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.use_rs1   = 1'b1;
        dec_ctrl.use_rs2   = 1'b1;
        dec_illegal        = !((funct7 == 7'b0000000) ||
                               ((funct7 == 7'b0100000) &&
                                (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OP_IMM_32: begin
        dec_fmt              = IMM_I;
        dec_alu              = alu_from_funct3(funct3, (funct3 == 3'b101) && if_instr[30]);
        dec_ctrl.reg_write   = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.is_word     = 1'b1;
        dec_ctrl.use_rs1     = 1'b1;
        case (funct3)
          3'b000:  dec_illegal = 1'b0;
          3'b001:  dec_illegal = (funct7 != 7'b0000000);
          3'b101:  dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        dec_alu            = alu_from_funct3(funct3, if_instr[30]);
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.is_word   = 1'b1;
        dec_ctrl.use_rs1   = 1'b1;
        dec_ctrl.use_rs2   = 1'b1;
        dec_illegal        = !((funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101) &&
                               ((funct7 == 7'b0000000) ||
                                ((funct7 == 7'b0100000) && (funct3 != 3'b001))));
      end
      default: dec_illegal = 1'b1;
    endcase

    if (if_instr == 32'h0000_0000) dec_illegal = 1'b1;
    if (rd == 5'd0) dec_ctrl.reg_write = 1'b0;
    if (dec_illegal) begin
      dec_ctrl = '0;
      dec_alu  = ALU_ADD;
      dec_fmt  = IMM_NONE;
    end
  end

  decode_stage_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr_i (if_instr[31:7]),
    .fmt_i   (dec_fmt),
    .imm_o   (dec_imm)
  );

  logic              valid_q, valid_d;
  logic              accept;
  logic [PC_W-1:0]   pc_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   imm_q;
  logic [3:0]        alu_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              illegal_q;

  assign if_ready = !valid_q || id_ready;
  assign accept   = if_valid && if_ready && !flush;

  always_comb begin
    valid_d = valid_q && !id_ready;
    if (accept) valid_d = 1'b1;
    if (flush)  valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      funct3_q  <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        pc_q      <= if_pc;
        rs1_q     <= if_instr[19:15];
        rs2_q     <= if_instr[24:20];
        rd_q      <= rd;
        funct3_q  <= funct3;
        imm_q     <= dec_imm;
        alu_q     <= dec_alu;
        ctrl_q    <= dec_ctrl;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign id_valid   = valid_q;
  assign id_pc      = pc_q;
  assign id_rs1     = rs1_q;
  assign id_rs2     = rs2_q;
  assign id_rd      = rd_q;
  assign id_funct3  = funct3_q;
  assign id_imm     = imm_q;
  assign id_alu_op  = alu_q;
  assign id_ctrl    = ctrl_q;
  assign id_illegal = illegal_q;

`ifdef DECODE_PERF_EN
  logic [CNT_W-1:0] decoded_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decoded_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (accept)               decoded_cnt_q <= decoded_cnt_q + 1'b1;
      if (valid_q && !id_ready) stall_cnt_q   <= stall_cnt_q + 1'b1;
    end
  end

  assign id_decoded_cnt = decoded_cnt_q;
  assign id_stall_cnt   = stall_cnt_q;
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_perf_cnt;
  assign unused_perf_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected bundles, a monitor pops on handshake.
module tb_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic [3:0]  alu;
    logic [9:0]  ctrl;
    logic        ill;
  } bundle_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = '0;
  logic [63:0] if_pc = '0;
  logic        flush = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [63:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [63:0] id_imm;
  logic [3:0]  id_alu_op;
  logic [9:0]  id_ctrl;
  logic        id_illegal;
`ifdef DECODE_PERF_EN
  logic [31:0] id_decoded_cnt, id_stall_cnt;
`endif

  decode_stage u_dut (
    .clk        (clk),
    .reset      (reset),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_funct3  (id_funct3),
    .id_imm     (id_imm),
    .id_alu_op  (id_alu_op),
    .id_ctrl    (id_ctrl),
    .id_illegal (id_illegal)
`ifdef DECODE_PERF_EN
    ,
    .id_decoded_cnt (id_decoded_cnt),
    .id_stall_cnt   (id_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  bundle_t sb[$];
  logic    m_valid = 1'b0;
  int      n_acc = 0;
  int      n_stall = 0;

  function automatic bundle_t mk(input logic [63:0] pc, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [63:0] imm,
                                 input logic [3:0] alu, input logic [9:0] ctrl,
                                 input logic ill);
    bundle_t b;
    b = '{pc: pc, rs1: rs1, rs2: rs2, rd: rd, f3: f3, imm: imm, alu: alu, ctrl: ctrl,
          ill: ill};
    return b;
  endfunction

  function automatic bundle_t dut_bundle();
    return '{pc: id_pc, rs1: id_rs1, rs2: id_rs2, rd: id_rd, f3: id_funct3, imm: id_imm,
             alu: id_alu_op, ctrl: id_ctrl, ill: id_illegal};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input string name, input bundle_t act, input bundle_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got pc=%h rs1=%0d rs2=%0d rd=%0d f3=%0d imm=%h alu=%0d ctrl=%h ill=%b expected pc=%h rs1=%0d rs2=%0d rd=%0d f3=%0d imm=%h alu=%0d ctrl=%h ill=%b",
               name, act.pc, act.rs1, act.rs2, act.rd, act.f3, act.imm, act.alu, act.ctrl,
               act.ill, exp.pc, exp.rs1, exp.rs2, exp.rd, exp.f3, exp.imm, exp.alu, exp.ctrl,
               exp.ill);
    end
  endtask

  // One clock of stimulus; the bench's own occupancy model decides what gets accepted.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic rdy, input logic fl, input bundle_t e);
    logic exp_rdy, acc;
    @(posedge clk);
    #1;
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
    id_ready = rdy;
    flush    = fl;
    #1;
    exp_rdy = !m_valid || rdy;
    chk("id_valid", {63'b0, id_valid}, {63'b0, m_valid});
    chk("if_ready", {63'b0, if_ready}, {63'b0, exp_rdy});
    acc = v && exp_rdy && !fl;
    if (fl && m_valid && !rdy && sb.size() > 0) void'(sb.pop_front());
    if (acc) begin
      sb.push_back(e);
      n_acc++;
    end
    if (m_valid && !rdy) n_stall++;
    m_valid = fl ? 1'b0 : (acc ? 1'b1 : (m_valid && !rdy));
  endtask

  bundle_t mon_act, mon_exp;
  always @(negedge clk) begin
    if (!reset && id_valid && id_ready) begin
      mon_act = dut_bundle();
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bundle got pc=%h with empty scoreboard", mon_act.pc);
      end else begin
        mon_exp = sb.pop_front();
        chk_bundle("bundle", mon_act, mon_exp);
      end
    end
  end

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  bundle_t nb, b_a, b_b;

  initial begin
    nb = '0;
    #12;
    chk("reset_id_valid", {63'b0, id_valid}, 64'd0);
    chk("reset_id_pc", id_pc, 64'd0);
    chk("reset_id_ctrl", {54'b0, id_ctrl}, 64'd0);
    chk("reset_id_imm", id_imm, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back decode at full throughput
    step(1, 32'hFFF00093, 64'h1000, 1, 0, mk(64'h1000, 0, 31, 1, 0, ONES, 0, 10'h20A, 0));
    step(1, 32'hFE000EE3, 64'h1004, 1, 0,
         mk(64'h1004, 0, 0, 29, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 10'h043, 0));
    step(1, 32'h123452B7, 64'h1008, 1, 0,
         mk(64'h1008, 8, 3, 5, 5, 64'h1234_5000, 10, 10'h208, 0));
    step(1, 32'h0020B423, 64'h100C, 1, 0, mk(64'h100C, 1, 2, 8, 3, 64'd8, 0, 10'h08B, 0));
    step(1, 32'h002081BB, 64'h1010, 1, 0, mk(64'h1010, 1, 2, 3, 0, 64'd0, 0, 10'h207, 0));
    step(1, 32'h40208033, 64'h1014, 1, 0, mk(64'h1014, 1, 2, 0, 0, 64'd0, 1, 10'h003, 0));
    step(1, 32'h001000EF, 64'h1018, 1, 0, mk(64'h1018, 0, 1, 1, 0, 64'h800, 0, 10'h220, 0));
    step(1, 32'h40335293, 64'h101C, 1, 0, mk(64'h101C, 6, 3, 5, 5, 64'h403, 7, 10'h20A, 0));
    step(1, 32'h00000000, 64'h1020, 1, 0, mk(64'h1020, 0, 0, 0, 0, 64'd0, 0, 10'h000, 1));
    step(1, 32'h0000007F, 64'h1024, 1, 0, mk(64'h1024, 0, 0, 0, 0, 64'd0, 0, 10'h000, 1));
    step(1, 32'h02208033, 64'h1028, 1, 0, mk(64'h1028, 1, 2, 0, 0, 64'd0, 0, 10'h000, 1));
    step(1, 32'h00000513, 64'h102C, 1, 0, mk(64'h102C, 0, 0, 10, 0, 64'd0, 0, 10'h20A, 0));

    // Back-pressure: outputs hold while stalled, then the waiting word goes in at once
    b_a = mk(64'h2000, 0, 31, 1, 0, ONES, 0, 10'h20A, 0);
    b_b = mk(64'h2004, 0, 0, 29, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 10'h043, 0);
    step(1, 32'hFFF00093, 64'h2000, 1, 0, b_a);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'hFE000EE3, 64'h2004, 0, 0, b_b);
      chk_bundle("stall_hold", dut_bundle(), b_a);
    end
    step(1, 32'hFE000EE3, 64'h2004, 1, 0, b_b);

    // Flush while full and stalled: held and incoming words both vanish
    step(1, 32'h123452B7, 64'h3000, 0, 0, nb);
    chk_bundle("stall_hold_b", dut_bundle(), b_b);
    step(1, 32'h0020B423, 64'h3004, 0, 1, mk(64'h3004, 1, 2, 8, 3, 64'd8, 0, 10'h08B, 0));
    step(0, 32'h0, 64'h0, 1, 0, nb);
    chk("flush_id_valid", {63'b0, id_valid}, 64'd0);
    step(0, 32'h0, 64'h0, 1, 0, nb);

    // Asynchronous reset while full and stalled
    step(1, 32'h002081BB, 64'h4000, 1, 0, mk(64'h4000, 1, 2, 3, 0, 64'd0, 0, 10'h207, 0));
    step(0, 32'h0, 64'h0, 0, 0, nb);
    @(posedge clk);
    #1;
`ifdef DECODE_PERF_EN
    chk("decoded_cnt", {32'b0, id_decoded_cnt}, n_acc);
    chk("stall_cnt", {32'b0, id_stall_cnt}, n_stall);
`endif
    reset = 1'b1;
    #1;
    chk("async_reset_id_valid", {63'b0, id_valid}, 64'd0);
    chk("async_reset_id_pc", id_pc, 64'd0);
    chk("async_reset_id_ctrl", {54'b0, id_ctrl}, 64'd0);
    sb.delete();
    m_valid = 1'b0;
    n_acc   = 0;
    n_stall = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_reset_if_ready", {63'b0, if_ready}, 64'd1);
`ifdef DECODE_PERF_EN
    chk("post_reset_decoded_cnt", {32'b0, id_decoded_cnt}, 64'd0);
    chk("post_reset_stall_cnt", {32'b0, id_stall_cnt}, 64'd0);
`endif

    step(1, 32'h00000513, 64'h5000, 1, 0, mk(64'h5000, 0, 0, 10, 0, 64'd0, 0, 10'h20A, 0));
    step(0, 32'h0, 64'h0, 1, 0, nb);
    step(0, 32'h0, 64'h0, 1, 0, nb);
    chk("scoreboard_drained", sb.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
